rename_regfile: RTL and testbench

- Architectural register file with a per-register rename table (busy bit plus ROB tag), generalised to superscalar width.
- Serves DISP_W dispatch lanes per cycle, each with two source reads and one destination rename.
- Retires up to CMT_W in-order ROB commits per cycle and bypasses CDB and ROB-ready results into the operand lookups.
- Sits between decode/dispatch and the reservation stations. The ROB drives the commit and flush ports.

---
 rtl/rv32i_types.sv | 25 ++
 rtl/operand_lookup.sv | 105 ++++++++++
 rtl/rename_regfile.sv | 147 ++++++++++++++
 tb/tb_rename_regfile.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared widths and record types for the rename register file.
package rv32i_types;

  localparam int unsigned XLEN_D      = 32;
  localparam int unsigned NREG_D      = 32;
  localparam int unsigned ROB_DEPTH_D = 8;
  localparam int unsigned DISP_W_D    = 2;
  localparam int unsigned CMT_W_D     = 2;
  localparam int unsigned CDB_W_D     = 2;
  localparam int unsigned TAG_W_D     = $clog2(ROB_DEPTH_D);
  localparam int unsigned REG_W_D     = $clog2(NREG_D);

  typedef struct packed {
    logic               busy;
    logic [TAG_W_D-1:0] tag;
    logic [XLEN_D-1:0]  data;
  } rename_entry_t;

  typedef struct packed {
    logic               rdy;
    logic [TAG_W_D-1:0] tag;
    logic [XLEN_D-1:0]  val;
  } operand_t;

endpackage

// File: rtl/operand_lookup.sv
// One source-operand lookup: resolves a register to a value or a producer tag,
// forwarding from earlier dispatch lanes, the CDB, the ROB and same-cycle commits.
module operand_lookup
  import rv32i_types::*;
#(
  parameter int unsigned XLEN      = XLEN_D,
  parameter int unsigned NREG      = NREG_D,
  parameter int unsigned ROB_DEPTH = ROB_DEPTH_D,
  parameter int unsigned DISP_W    = DISP_W_D,
  parameter int unsigned CMT_W     = CMT_W_D,
  parameter int unsigned CDB_W     = CDB_W_D,
  parameter int unsigned LANE      = 0,
  localparam int unsigned TAG_W    = $clog2(ROB_DEPTH),
  localparam int unsigned RW       = $clog2(NREG)
) (
  input  logic [RW-1:0]                    src,
  input  logic                             ent_busy,
  input  logic [TAG_W-1:0]                 ent_tag,
  input  logic [XLEN-1:0]                  ent_data,
  input  logic [DISP_W-1:0]                disp_valid,
  input  logic [DISP_W-1:0][RW-1:0]        disp_rd,
  input  logic [DISP_W-1:0][TAG_W-1:0]     disp_tag,
  input  logic [CDB_W-1:0]                 cdb_valid,
  input  logic [CDB_W-1:0][TAG_W-1:0]      cdb_tag,
  input  logic [CDB_W-1:0][XLEN-1:0]       cdb_data,
  input  logic [ROB_DEPTH-1:0]             rob_rdy,
  input  logic [ROB_DEPTH-1:0][XLEN-1:0]   rob_data,
  input  logic [CMT_W-1:0]                 cmt_valid,
  input  logic [CMT_W-1:0][RW-1:0]         cmt_rd,
  input  logic [CMT_W-1:0][TAG_W-1:0]      cmt_tag,
  input  logic [CMT_W-1:0][XLEN-1:0]       cmt_data,
  output logic                             rdy,
  output logic [TAG_W-1:0]                 tag,
  output logic [XLEN-1:0]                  val
);

  logic             early_hit;
  logic [TAG_W-1:0] early_tag;
  logic             cdb_hit;
  logic [XLEN-1:0]  cdb_val;
  logic             own_hit;
  logic [XLEN-1:0]  own_val;
  logic             fwd_hit;
  logic [XLEN-1:0]  fwd_val;

  always_comb begin
    early_hit = 1'b0;
    early_tag = '0;
    // Later lanes overwrite, so the youngest earlier lane renaming src wins.
    for (int unsigned j = 0; j < DISP_W; j++) begin
      if (j < LANE && disp_valid[j] && disp_rd[j] == src) begin
        early_hit = 1'b1;
        early_tag = disp_tag[j];
      end
    end

    cdb_hit = 1'b0;
    cdb_val = '0;
    for (int unsigned k = 0; k < CDB_W; k++) begin
      if (!cdb_hit && cdb_valid[k] && cdb_tag[k] == ent_tag) begin
        cdb_hit = 1'b1;
        cdb_val = cdb_data[k];
      end
    end

    own_hit = 1'b0;
    own_val = '0;
    fwd_hit = 1'b0;
    fwd_val = '0;
    for (int unsigned c = 0; c < CMT_W; c++) begin
      if (cmt_valid[c] && cmt_rd[c] == src) begin
        fwd_hit = 1'b1;
        fwd_val = cmt_data[c];
        if (cmt_tag[c] == ent_tag) begin
          own_hit = 1'b1;
          own_val = cmt_data[c];
        end
      end
    end
  end

  always_comb begin
    rdy = 1'b1;
    tag = '0;
    val = '0;
    if (src == '0) begin
      rdy = 1'b1;
    end else if (early_hit) begin
      rdy = 1'b0;
      tag = early_tag;
    end else if (ent_busy && cdb_hit) begin
      val = cdb_val;
    end else if (ent_busy && rob_rdy[ent_tag]) begin
      val = rob_data[ent_tag];
    end else if (ent_busy && own_hit) begin
      val = own_val;
    end else if (ent_busy) begin
      rdy = 1'b0;
      tag = ent_tag;
    end else begin
      val = fwd_hit ? fwd_val : ent_data;
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register busy/tag rename state, serving
// several dispatch lanes and in-order commit ports per cycle.
module rename_regfile
  import rv32i_types::*;
#(
  parameter int unsigned XLEN      = XLEN_D,
  parameter int unsigned NREG      = NREG_D,
  parameter int unsigned ROB_DEPTH = ROB_DEPTH_D,
  parameter int unsigned DISP_W    = DISP_W_D,
  parameter int unsigned CMT_W     = CMT_W_D,
  parameter int unsigned CDB_W     = CDB_W_D,
  localparam int unsigned TAG_W    = $clog2(ROB_DEPTH),
  localparam int unsigned RW       = $clog2(NREG)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DISP_W-1:0]                disp_valid,
  input  logic [DISP_W-1:0][RW-1:0]        disp_rd,
  input  logic [DISP_W-1:0][TAG_W-1:0]     disp_tag,
  input  logic [DISP_W-1:0][RW-1:0]        disp_rs1,
  input  logic [DISP_W-1:0][RW-1:0]        disp_rs2,
  output logic [DISP_W-1:0]                op1_rdy,
  output logic [DISP_W-1:0]                op2_rdy,
  output logic [DISP_W-1:0][XLEN-1:0]      op1_val,
  output logic [DISP_W-1:0][XLEN-1:0]      op2_val,
  output logic [DISP_W-1:0][TAG_W-1:0]     op1_tag,
  output logic [DISP_W-1:0][TAG_W-1:0]     op2_tag,
  input  logic [CDB_W-1:0]                 cdb_valid,
  input  logic [CDB_W-1:0][TAG_W-1:0]      cdb_tag,
  input  logic [CDB_W-1:0][XLEN-1:0]       cdb_data,
  input  logic [ROB_DEPTH-1:0]             rob_rdy,
  input  logic [ROB_DEPTH-1:0][XLEN-1:0]   rob_data,
  input  logic [CMT_W-1:0]                 cmt_valid,
  input  logic [CMT_W-1:0][RW-1:0]         cmt_rd,
  input  logic [CMT_W-1:0][TAG_W-1:0]      cmt_tag,
  input  logic [CMT_W-1:0][XLEN-1:0]       cmt_data,
  input  logic                             flush_valid
);

  logic [NREG-1:0][XLEN-1:0]  data_q, data_d;
  logic [NREG-1:0]            busy_q, busy_d;
  logic [NREG-1:0][TAG_W-1:0] tag_q, tag_d;

  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    // Commits: data always lands; busy clears only if this commit still owns the register.
    for (int unsigned c = 0; c < CMT_W; c++) begin
      if (cmt_valid[c] && cmt_rd[c] != '0) begin
        data_d[cmt_rd[c]] = cmt_data[c];
        if (tag_q[cmt_rd[c]] == cmt_tag[c]) begin
          busy_d[cmt_rd[c]] = 1'b0;
        end
      end
    end
    if (flush_valid) begin
      busy_d = '0;
    end else begin
      for (int unsigned l = 0; l < DISP_W; l++) begin
        if (disp_valid[l] && disp_rd[l] != '0) begin
          busy_d[disp_rd[l]] = 1'b1;
          tag_d[disp_rd[l]]  = disp_tag[l];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  logic [DISP_W-1:0]             l1_rdy, l2_rdy;
  logic [DISP_W-1:0][XLEN-1:0]   l1_val, l2_val;
  logic [DISP_W-1:0][TAG_W-1:0]  l1_tag, l2_tag;

  for (genvar l = 0; l < DISP_W; l++) begin : g_lane
    operand_lookup #(
      .XLEN(XLEN), .NREG(NREG), .ROB_DEPTH(ROB_DEPTH),
      .DISP_W(DISP_W), .CMT_W(CMT_W), .CDB_W(CDB_W), .LANE(l)
    ) u_rs1 (
      .src        (disp_rs1[l]),
      .ent_busy   (busy_q[disp_rs1[l]]),
      .ent_tag    (tag_q[disp_rs1[l]]),
      .ent_data   (data_q[disp_rs1[l]]),
      .disp_valid (disp_valid),
      .disp_rd    (disp_rd),
      .disp_tag   (disp_tag),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_data   (cdb_data),
      .rob_rdy    (rob_rdy),
      .rob_data   (rob_data),
      .cmt_valid  (cmt_valid),
      .cmt_rd     (cmt_rd),
      .cmt_tag    (cmt_tag),
      .cmt_data   (cmt_data),
      .rdy        (l1_rdy[l]),
      .tag        (l1_tag[l]),
      .val        (l1_val[l])
    );

    operand_lookup #(
      .XLEN(XLEN), .NREG(NREG), .ROB_DEPTH(ROB_DEPTH),
      .DISP_W(DISP_W), .CMT_W(CMT_W), .CDB_W(CDB_W), .LANE(l)
    ) u_rs2 (
      .src        (disp_rs2[l]),
      .ent_busy   (busy_q[disp_rs2[l]]),
      .ent_tag    (tag_q[disp_rs2[l]]),
      .ent_data   (data_q[disp_rs2[l]]),
      .disp_valid (disp_valid),
      .disp_rd    (disp_rd),
      .disp_tag   (disp_tag),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_data   (cdb_data),
      .rob_rdy    (rob_rdy),
      .rob_data   (rob_data),
      .cmt_valid  (cmt_valid),
      .cmt_rd     (cmt_rd),
      .cmt_tag    (cmt_tag),
      .cmt_data   (cmt_data),
      .rdy        (l2_rdy[l]),
      .tag        (l2_tag[l]),
      .val        (l2_val[l])
    );
  end

  // Under reset every operand reads as a ready zero, regardless of inputs.
  always_comb begin
    op1_rdy = rst ? '1 : l1_rdy;
    op2_rdy = rst ? '1 : l2_rdy;
    op1_val = rst ? '0 : l1_val;
    op2_val = rst ? '0 : l2_val;
    op1_tag = rst ? '0 : l1_tag;
    op2_tag = rst ? '0 : l2_tag;
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Bench for rename_regfile: directed scenarios with literal expectations, then
// random traffic checked every cycle against an array-based model of the register state.
module tb_rename_regfile;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int ROB  = 8;
  localparam int DW   = 2;
  localparam int CW   = 2;
  localparam int BW   = 2;
  localparam int RW   = 5;
  localparam int TW   = 3;

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0]           disp_valid;
  logic [DW-1:0][RW-1:0]   disp_rd, disp_rs1, disp_rs2;
  logic [DW-1:0][TW-1:0]   disp_tag;
  logic [DW-1:0]           op1_rdy, op2_rdy;
  logic [DW-1:0][XLEN-1:0] op1_val, op2_val;
  logic [DW-1:0][TW-1:0]   op1_tag, op2_tag;
  logic [BW-1:0]           cdb_valid;
  logic [BW-1:0][TW-1:0]   cdb_tag;
  logic [BW-1:0][XLEN-1:0] cdb_data;
  logic [ROB-1:0]          rob_rdy;
  logic [ROB-1:0][XLEN-1:0] rob_data;
  logic [CW-1:0]           cmt_valid;
  logic [CW-1:0][RW-1:0]   cmt_rd;
  logic [CW-1:0][TW-1:0]   cmt_tag;
  logic [CW-1:0][XLEN-1:0] cmt_data;
  logic                    flush_valid;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_data [NREG];
  bit          m_busy [NREG];
  int          m_tag  [NREG];

  always #5 clk = ~clk;

  rename_regfile dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_tag(disp_tag),
    .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .op1_rdy(op1_rdy), .op2_rdy(op2_rdy), .op1_val(op1_val), .op2_val(op2_val),
    .op1_tag(op1_tag), .op2_tag(op2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rob_rdy(rob_rdy), .rob_data(rob_data),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_data(cmt_data),
    .flush_valid(flush_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_data[r] = '0;
      m_busy[r] = 1'b0;
      m_tag[r]  = 0;
    end
  endfunction

  // What a lookup of register s on a lane must return, given current inputs and model state.
  function automatic void model_op(input int lane, input int s, output bit rdy, output int tag,
                                   output logic [31:0] val);
    int t;
    rdy = 1'b1;
    tag = 0;
    val = '0;
    if (rst || s == 0) return;
    for (int j = lane - 1; j >= 0; j--) begin
      if (disp_valid[j] && int'(disp_rd[j]) == s) begin
        rdy = 1'b0;
        tag = int'(disp_tag[j]);
        return;
      end
    end
    if (m_busy[s]) begin
      t = m_tag[s];
      for (int k = 0; k < BW; k++) begin
        if (cdb_valid[k] && int'(cdb_tag[k]) == t) begin
          val = cdb_data[k];
          return;
        end
      end
      if (rob_rdy[t]) begin
        val = rob_data[t];
        return;
      end
      for (int c = CW - 1; c >= 0; c--) begin
        if (cmt_valid[c] && int'(cmt_tag[c]) == t && int'(cmt_rd[c]) == s) begin
          val = cmt_data[c];
          return;
        end
      end
      rdy = 1'b0;
      tag = t;
      return;
    end
    for (int c = CW - 1; c >= 0; c--) begin
      if (cmt_valid[c] && int'(cmt_rd[c]) == s) begin
        val = cmt_data[c];
        return;
      end
    end
    val = m_data[s];
  endfunction

  // Clock-edge effect of the current inputs on the model.
  function automatic void model_update();
    int owner [NREG];
    if (rst) begin
      model_reset();
      return;
    end
    for (int r = 0; r < NREG; r++) owner[r] = m_tag[r];
    for (int c = 0; c < CW; c++) begin
      if (cmt_valid[c] && cmt_rd[c] != 0) begin
        m_data[cmt_rd[c]] = cmt_data[c];
        if (owner[cmt_rd[c]] == int'(cmt_tag[c])) m_busy[cmt_rd[c]] = 1'b0;
      end
    end
    if (flush_valid) begin
      for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        for (int l = DW - 1; l >= 0; l--) begin
          if (disp_valid[l] && int'(disp_rd[l]) == r) begin
            m_busy[r] = 1'b1;
            m_tag[r]  = int'(disp_tag[l]);
            break;
          end
        end
      end
    end
  endfunction

  function automatic void dut_op(input int lane, input int w, output bit rdy, output int tag,
                                 output logic [31:0] val);
    rdy = (w == 1) ? op1_rdy[lane] : op2_rdy[lane];
    tag = (w == 1) ? int'(op1_tag[lane]) : int'(op2_tag[lane]);
    val = (w == 1) ? op1_val[lane] : op2_val[lane];
  endfunction

  task automatic compare_all();
    bit er, dr;
    int et, dt, s;
    logic [31:0] ev, dv;
    for (int l = 0; l < DW; l++) begin
      for (int w = 1; w <= 2; w++) begin
        s = (w == 1) ? int'(disp_rs1[l]) : int'(disp_rs2[l]);
        model_op(l, s, er, et, ev);
        dut_op(l, w, dr, dt, dv);
        chk($sformatf("model L%0d op%0d x%0d rdy", l, w, s), 32'(dr), 32'(er));
        if (er) chk($sformatf("model L%0d op%0d x%0d val", l, w, s), dv, ev);
        else    chk($sformatf("model L%0d op%0d x%0d tag", l, w, s), 32'(dt), 32'(et));
      end
    end
  endtask

  task automatic expect_op(input int lane, input int w, input bit r, input logic [31:0] v);
    bit dr;
    int dt;
    logic [31:0] dv;
    dut_op(lane, w, dr, dt, dv);
    chk($sformatf("lit L%0d op%0d rdy", lane, w), 32'(dr), 32'(r));
    if (r) chk($sformatf("lit L%0d op%0d val", lane, w), dv, v);
    else   chk($sformatf("lit L%0d op%0d tag", lane, w), 32'(dt), v);
  endtask

  task automatic set_idle();
    disp_valid = '0; disp_rd = '0; disp_tag = '0; disp_rs1 = '0; disp_rs2 = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    rob_rdy = '0; rob_data = '0;
    cmt_valid = '0; cmt_rd = '0; cmt_tag = '0; cmt_data = '0;
    flush_valid = 1'b0;
  endtask

  // Called at the falling edge: check outputs, cross the rising edge, update model, idle inputs.
  task automatic tick();
    if (rst || !flush_valid) compare_all();
    @(posedge clk);
    model_update();
    #1;
    set_idle();
  endtask

  task automatic randomize_inputs();
    int rd;
    for (int l = 0; l < DW; l++) begin
      disp_valid[l] = 1'($urandom_range(0, 1));
      disp_rd[l]    = 5'($urandom_range(0, 7));
      disp_tag[l]   = 3'($urandom_range(0, 7));
      disp_rs1[l]   = 5'($urandom_range(0, 8));
      disp_rs2[l]   = 5'($urandom_range(0, 8));
    end
    for (int c = 0; c < CW; c++) begin
      rd = $urandom_range(0, 7);
      cmt_valid[c] = 1'($urandom_range(0, 1));
      cmt_rd[c]    = 5'(rd);
      cmt_tag[c]   = $urandom_range(0, 1) ? 3'(m_tag[rd]) : 3'($urandom_range(0, 7));
      cmt_data[c]  = $urandom;
    end
    for (int k = 0; k < BW; k++) begin
      cdb_valid[k] = ($urandom_range(0, 3) == 0);
      cdb_tag[k]   = 3'($urandom_range(0, 7));
      cdb_data[k]  = $urandom;
    end
    rob_rdy = 8'($urandom & $urandom & $urandom);
    for (int e = 0; e < ROB; e++) rob_data[e] = $urandom;
    flush_valid = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    model_reset();
    disp_rs1[0] = 5'd5;
    cmt_valid[0] = 1'b1; cmt_rd[0] = 5'd5; cmt_data[0] = 32'h77;
    @(negedge clk);
    expect_op(0, 1, 1'b1, 32'h0);
    tick();
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Fresh register reads as ready zero on both lanes.
    disp_rs1[0] = 5'd5; disp_rs1[1] = 5'd5;
    @(negedge clk);
    expect_op(0, 1, 1'b1, 32'h0);
    expect_op(1, 1, 1'b1, 32'h0);
    tick();

    // Rename x3 -> tag 2, then wake it from the CDB in the same cycle.
    disp_valid[0] = 1'b1; disp_rd[0] = 5'd3; disp_tag[0] = 3'd2;
    @(negedge clk);
    tick();
    disp_rs1[0] = 5'd3;
    @(negedge clk);
    expect_op(0, 1, 1'b0, 32'd2);
    cdb_valid[0] = 1'b1; cdb_tag[0] = 3'd2; cdb_data[0] = 32'hDEAD;
    #1;
    expect_op(0, 1, 1'b1, 32'hDEAD);
    tick();

    // Lane 1 sees lane 0's rename of x4; its own rename of x6 does not affect its read of x6.
    disp_valid = 2'b11;
    disp_rd[0] = 5'd4; disp_tag[0] = 3'd1; disp_rs1[1] = 5'd4;
    disp_rd[1] = 5'd6; disp_tag[1] = 3'd7; disp_rs2[1] = 5'd6;
    @(negedge clk);
    expect_op(1, 1, 1'b0, 32'd1);
    expect_op(1, 2, 1'b1, 32'h0);
    tick();

    // x7 renamed twice; the stale commit writes data but leaves the younger owner.
    disp_valid[0] = 1'b1; disp_rd[0] = 5'd7; disp_tag[0] = 3'd3;
    @(negedge clk);
    tick();
    disp_valid[0] = 1'b1; disp_rd[0] = 5'd7; disp_tag[0] = 3'd5;
    @(negedge clk);
    tick();
    cmt_valid[0] = 1'b1; cmt_rd[0] = 5'd7; cmt_tag[0] = 3'd3; cmt_data[0] = 32'h11;
    disp_rs1[0] = 5'd7;
    @(negedge clk);
    expect_op(0, 1, 1'b0, 32'd5);
    tick();
    disp_rs1[0] = 5'd7;
    @(negedge clk);
    expect_op(0, 1, 1'b0, 32'd5);
    cmt_valid[0] = 1'b1; cmt_rd[0] = 5'd7; cmt_tag[0] = 3'd5; cmt_data[0] = 32'h22;
    #1;
    expect_op(0, 1, 1'b1, 32'h22);
    tick();
    disp_rs1[0] = 5'd7;
    @(negedge clk);
    expect_op(0, 1, 1'b1, 32'h22);
    tick();

    // Two commits to x9: youngest data wins and the owning tag clears busy.
    disp_valid[0] = 1'b1; disp_rd[0] = 5'd9; disp_tag[0] = 3'd6;
    @(negedge clk);
    tick();
    cmt_valid = 2'b11;
    cmt_rd[0] = 5'd9; cmt_tag[0] = 3'd4; cmt_data[0] = 32'hA;
    cmt_rd[1] = 5'd9; cmt_tag[1] = 3'd6; cmt_data[1] = 32'hB;
    disp_rs1[0] = 5'd9;
    @(negedge clk);
    expect_op(0, 1, 1'b1, 32'hB);
    tick();
    disp_rs1[0] = 5'd9;
    @(negedge clk);
    expect_op(0, 1, 1'b1, 32'hB);
    tick();

    // Flush with a commit to x2 and a dispatch to x10 that must be dropped.
    disp_valid = 2'b11;
    disp_rd[0] = 5'd2; disp_tag[0] = 3'd1;
    disp_rd[1] = 5'd8; disp_tag[1] = 3'd2;
    @(negedge clk);
    tick();
    flush_valid = 1'b1;
    cmt_valid[0] = 1'b1; cmt_rd[0] = 5'd2; cmt_tag[0] = 3'd1; cmt_data[0] = 32'h5;
    disp_valid[0] = 1'b1; disp_rd[0] = 5'd10; disp_tag[0] = 3'd3;
    @(negedge clk);
    tick();
    disp_rs1[0] = 5'd2; disp_rs2[0] = 5'd8; disp_rs1[1] = 5'd10;
    @(negedge clk);
    expect_op(0, 1, 1'b1, 32'h5);
    expect_op(0, 2, 1'b1, 32'h0);
    expect_op(1, 1, 1'b1, 32'h0);
    tick();

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        // Asynchronous reset pulse between clock edges.
        #1 rst = 1'b1;
        #1 compare_all();
        model_reset();
        rst = 1'b0;
      end
      randomize_inputs();
      @(negedge clk);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
